// File: rtl/uart_tx_fifo_if.sv
// Host-side bus of the buffered UART transmitter: write strobe, data, FIFO
// status and the serial line, with host (master) and transmitter (slave) views.
interface uart_tx_fifo_if #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4
) ();
  logic                               cs;
  logic                               wr_en;
  logic [DATA_BITS-1:0]               wr_data;
  logic                               fifo_full;
  logic                               fifo_empty;
  logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_level;
  logic                               overflow;
  logic                               busy;
  logic                               tx_out;
  logic                               tx_complete;

  modport master (
    output cs, wr_en, wr_data,
    input  fifo_full, fifo_empty, fifo_level, overflow, busy, tx_out, tx_complete
  );

  modport slave (
    input  cs, wr_en, wr_data,
    output fifo_full, fifo_empty, fifo_level, overflow, busy, tx_out, tx_complete
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: a write FIFO feeds a framing FSM that sends start,
// data (LSb first), optional parity and 1-2 stop bits; all outputs registered.
module uart_tx_fifo #(
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int CLKS_PER_BIT = 104,
  parameter int FIFO_DEPTH   = 4
) (
  input logic           sourceClk,
  input logic           reset,
  uart_tx_fifo_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = $clog2(FIFO_DEPTH + 1);
  localparam int TW = $clog2(CLKS_PER_BIT);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4,
    S_DONE   = 3'd5
  } state_e;

  function automatic logic frame_parity(input logic [DATA_BITS-1:0] w);
    if (PARITY == 2) begin
      return ~^w;
    end else begin
      return ^w;
    end
  endfunction

  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]        level_q, level_d;
  logic                 full_q, empty_q, overflow_q;
  state_e               state_q, state_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic [3:0]           bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d, head_s;
  logic                 par_q, par_d;
  logic                 tx_q, tx_d, busy_q, done_q;
  logic                 push_s, pop_s, bit_end_s;

  // Full is the registered flag, so a pop in the same cycle never makes room.
  assign push_s    = bus.cs & bus.wr_en & ~full_q;
  assign head_s    = mem_q[rd_ptr_q];
  assign bit_end_s = (timer_q == TW'(CLKS_PER_BIT - 1));

  // FIFO occupancy after this cycle's push and pop.
  always_comb begin
    level_d = level_q;
    case ({push_s, pop_s})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // Framing FSM: next state, bit timing, FIFO pop and next line level.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    pop_s     = 1'b0;
    tx_d      = 1'b1;
    case (state_q)
      S_IDLE, S_DONE: begin
        timer_d   = TW'(0);
        bit_cnt_d = 4'd0;
        if (!empty_q) begin
          pop_s   = 1'b1;
          shift_d = head_s;
          par_d   = frame_parity(head_s);
          state_d = S_START;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        tx_d = 1'b0;
        if (bit_end_s) begin
          timer_d = TW'(0);
          state_d = S_DATA;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_DATA: begin
        tx_d = shift_q[0];
        if (bit_end_s) begin
          timer_d = TW'(0);
          shift_d = shift_q >> 1;
          if (bit_cnt_q == 4'(DATA_BITS - 1)) begin
            bit_cnt_d = 4'd0;
            state_d   = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_PARITY: begin
        tx_d = par_q;
        if (bit_end_s) begin
          timer_d = TW'(0);
          state_d = S_STOP;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_STOP: begin
        tx_d = 1'b1;
        if (bit_end_s) begin
          timer_d = TW'(0);
          if (bit_cnt_q == 4'(STOP_BITS - 1)) begin
            bit_cnt_d = 4'd0;
            state_d   = S_DONE;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // FIFO storage; contents need no reset since the level gates every read.
  always_ff @(posedge sourceClk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= bus.wr_data;
    end
  end

  // State, pointers, flags and the line; the line lags the FSM by one cycle.
  always_ff @(posedge sourceClk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q   <= AW'(0);
      rd_ptr_q   <= AW'(0);
      level_q    <= LW'(0);
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
      state_q    <= S_IDLE;
      timer_q    <= TW'(0);
      bit_cnt_q  <= 4'd0;
      shift_q    <= {DATA_BITS{1'b0}};
      par_q      <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      wr_ptr_q   <= push_s ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_q   <= pop_s ? rd_ptr_q + AW'(1) : rd_ptr_q;
      level_q    <= level_d;
      full_q     <= (level_d == LW'(FIFO_DEPTH));
      empty_q    <= (level_d == LW'(0));
      overflow_q <= bus.cs & bus.wr_en & full_q;
      state_q    <= state_d;
      timer_q    <= timer_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      tx_q       <= tx_d;
      busy_q     <= (state_q != S_IDLE);
      done_q     <= (state_q == S_DONE);
    end
  end

  assign bus.fifo_full   = full_q;
  assign bus.fifo_empty  = empty_q;
  assign bus.fifo_level  = level_q;
  assign bus.overflow    = overflow_q;
  assign bus.busy        = busy_q;
  assign bus.tx_out      = tx_q;
  assign bus.tx_complete = done_q;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: four configurations side by side, every frame checked
// cycle by cycle against a bit-list model of the UART frame.
module tb_uart_tx_fifo;
  localparam int C = 4;
  localparam int DB  [4] = '{8, 8, 8, 7};
  localparam int PAR [4] = '{0, 1, 2, 0};
  localparam int SB  [4] = '{1, 1, 1, 2};

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] cs_v = 4'd0, we_v = 4'd0;
  logic [8:0] wd_v [4] = '{9'd0, 9'd0, 9'd0, 9'd0};
  logic [3:0] tx_v, busy_v, done_v, full_v, empty_v, ovf_v;
  logic [2:0] lvl_v [4];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_tx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) if_a ();
  uart_tx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) if_b ();
  uart_tx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) if_c ();
  uart_tx_fifo_if #(.DATA_BITS(7), .FIFO_DEPTH(4)) if_d ();

  uart_tx_fifo #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .CLKS_PER_BIT(C), .FIFO_DEPTH(4))
    dut_a (.sourceClk(clk), .reset(rst_n), .bus(if_a));
  uart_tx_fifo #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .CLKS_PER_BIT(C), .FIFO_DEPTH(4))
    dut_b (.sourceClk(clk), .reset(rst_n), .bus(if_b));
  uart_tx_fifo #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .CLKS_PER_BIT(C), .FIFO_DEPTH(4))
    dut_c (.sourceClk(clk), .reset(rst_n), .bus(if_c));
  uart_tx_fifo #(.DATA_BITS(7), .PARITY(0), .STOP_BITS(2), .CLKS_PER_BIT(C), .FIFO_DEPTH(4))
    dut_d (.sourceClk(clk), .reset(rst_n), .bus(if_d));

  assign if_a.cs = cs_v[0];  assign if_a.wr_en = we_v[0];  assign if_a.wr_data = wd_v[0][7:0];
  assign if_b.cs = cs_v[1];  assign if_b.wr_en = we_v[1];  assign if_b.wr_data = wd_v[1][7:0];
  assign if_c.cs = cs_v[2];  assign if_c.wr_en = we_v[2];  assign if_c.wr_data = wd_v[2][7:0];
  assign if_d.cs = cs_v[3];  assign if_d.wr_en = we_v[3];  assign if_d.wr_data = wd_v[3][6:0];

  assign tx_v    = {if_d.tx_out, if_c.tx_out, if_b.tx_out, if_a.tx_out};
  assign busy_v  = {if_d.busy, if_c.busy, if_b.busy, if_a.busy};
  assign done_v  = {if_d.tx_complete, if_c.tx_complete, if_b.tx_complete, if_a.tx_complete};
  assign full_v  = {if_d.fifo_full, if_c.fifo_full, if_b.fifo_full, if_a.fifo_full};
  assign empty_v = {if_d.fifo_empty, if_c.fifo_empty, if_b.fifo_empty, if_a.fifo_empty};
  assign ovf_v   = {if_d.overflow, if_c.overflow, if_b.overflow, if_a.overflow};
  assign lvl_v[0] = if_a.fifo_level;
  assign lvl_v[1] = if_b.fifo_level;
  assign lvl_v[2] = if_c.fifo_level;
  assign lvl_v[3] = if_d.fifo_level;

  // Reference frame: start, data LSb first, parity from a count of ones, stop bits.
  function automatic int frame_nbits(input int inst);
    return 1 + DB[inst] + ((PAR[inst] != 0) ? 1 : 0) + SB[inst];
  endfunction

  function automatic logic frame_bit(input int inst, input logic [8:0] w, input int idx);
    int ones;
    ones = 0;
    for (int i = 0; i < DB[inst]; i++) ones += int'(w[i]);
    if (idx == 0) return 1'b0;
    if (idx <= DB[inst]) return w[idx-1];
    if (PAR[inst] != 0 && idx == DB[inst] + 1)
      return (PAR[inst] == 1) ? ((ones % 2) == 1) : ((ones % 2) == 0);
    return 1'b1;
  endfunction

  task automatic do_write(input int inst, input logic [8:0] w);
    cs_v[inst] = 1'b1;
    we_v[inst] = 1'b1;
    wd_v[inst] = w;
    @(negedge clk);
    cs_v[inst] = 1'b0;
    we_v[inst] = 1'b0;
  endtask

  task automatic wait_start(input int inst, input int max);
    int n;
    n = 0;
    while (tx_v[inst] !== 1'b0 && n < max) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= max) begin
      errors++;
      $display("FAIL start_timeout inst=%0d: no start bit within %0d cycles", inst, max);
    end
  endtask

  // Entered on the first start-bit sample; leaves one sample after the completion pulse.
  task automatic check_frame(input int inst, input logic [8:0] w, input bit last);
    logic exp_b;
    for (int b = 0; b < frame_nbits(inst); b++) begin
      exp_b = frame_bit(inst, w, b);
      for (int c = 0; c < C; c++) begin
        checks++;
        if (tx_v[inst] !== exp_b || busy_v[inst] !== 1'b1 || done_v[inst] !== 1'b0) begin
          errors++;
          $display("FAIL frame inst=%0d word=%h bit=%0d cyc=%0d: tx=%b busy=%b done=%b, expected tx=%b busy=1 done=0",
                   inst, w, b, c, tx_v[inst], busy_v[inst], done_v[inst], exp_b);
        end
        @(negedge clk);
      end
    end
    checks++;
    if (tx_v[inst] !== 1'b1 || done_v[inst] !== 1'b1) begin
      errors++;
      $display("FAIL frame_end inst=%0d word=%h: tx=%b done=%b, expected tx=1 done=1",
               inst, w, tx_v[inst], done_v[inst]);
    end
    @(negedge clk);
    if (last) begin
      checks++;
      if (tx_v[inst] !== 1'b1 || done_v[inst] !== 1'b0 || busy_v[inst] !== 1'b0) begin
        errors++;
        $display("FAIL frame_idle inst=%0d: tx=%b done=%b busy=%b, expected 1 0 0",
                 inst, tx_v[inst], done_v[inst], busy_v[inst]);
      end
    end
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (tx_v[i] !== 1'b1 || busy_v[i] !== 1'b0 || done_v[i] !== 1'b0 || full_v[i] !== 1'b0 ||
          empty_v[i] !== 1'b1 || ovf_v[i] !== 1'b0 || lvl_v[i] !== 3'd0) begin
        errors++;
        $display("FAIL reset inst=%0d: tx=%b busy=%b done=%b full=%b empty=%b ovf=%b lvl=%0d, expected 1 0 0 0 1 0 0",
                 i, tx_v[i], busy_v[i], done_v[i], full_v[i], empty_v[i], ovf_v[i], lvl_v[i]);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_8n1();
    do_write(0, 9'h0A5);
    checks++;
    if (lvl_v[0] !== 3'd1 || empty_v[0] !== 1'b0 || tx_v[0] !== 1'b1 || busy_v[0] !== 1'b0) begin
      errors++;
      $display("FAIL write_flags: lvl=%0d empty=%b tx=%b busy=%b, expected 1 0 1 0",
               lvl_v[0], empty_v[0], tx_v[0], busy_v[0]);
    end
    @(negedge clk);
    checks++;
    if (tx_v[0] !== 1'b1) begin
      errors++;
      $display("FAIL latency: tx=%b one edge after write+1, expected 1", tx_v[0]);
    end
    @(negedge clk);
    check_frame(0, 9'h0A5, 1'b1);
  endtask

  task automatic test_parity();
    do_write(1, 9'h007);  @(negedge clk);  @(negedge clk);  check_frame(1, 9'h007, 1'b1);
    do_write(2, 9'h003);  @(negedge clk);  @(negedge clk);  check_frame(2, 9'h003, 1'b1);
    do_write(1, 9'h003);  @(negedge clk);  @(negedge clk);  check_frame(1, 9'h003, 1'b1);
  endtask

  task automatic test_config();
    do_write(3, 9'h07F);  @(negedge clk);  @(negedge clk);  check_frame(3, 9'h07F, 1'b1);
  endtask

  task automatic test_fifo();
    logic [8:0] lead;
    lead = 9'($urandom_range(0, 255));
    fork
      begin
        do_write(0, lead);
        do_write(0, 9'h011);
        do_write(0, 9'h022);
        do_write(0, 9'h033);
        do_write(0, 9'h044);
        checks++;
        if (full_v[0] !== 1'b1 || lvl_v[0] !== 3'd4 || ovf_v[0] !== 1'b0) begin
          errors++;
          $display("FAIL fifo_fill: full=%b lvl=%0d ovf=%b, expected 1 4 0", full_v[0], lvl_v[0], ovf_v[0]);
        end
        do_write(0, 9'h055);
        checks++;
        if (ovf_v[0] !== 1'b1 || lvl_v[0] !== 3'd4 || full_v[0] !== 1'b1) begin
          errors++;
          $display("FAIL overflow: ovf=%b lvl=%0d full=%b, expected 1 4 1", ovf_v[0], lvl_v[0], full_v[0]);
        end
        @(negedge clk);
        checks++;
        if (ovf_v[0] !== 1'b0) begin
          errors++;
          $display("FAIL overflow_pulse: ovf=%b one cycle later, expected 0", ovf_v[0]);
        end
      end
      begin
        wait_start(0, 20);
        check_frame(0, lead, 1'b0);
        check_frame(0, 9'h011, 1'b0);
        check_frame(0, 9'h022, 1'b0);
        check_frame(0, 9'h033, 1'b0);
        check_frame(0, 9'h044, 1'b1);
      end
    join
  endtask

  task automatic test_random();
    logic [8:0] ws [4];
    int k, inst;
    for (int it = 0; it < 8; it++) begin
      inst = it % 4;
      k = $urandom_range(1, 4);
      for (int i = 0; i < 4; i++) ws[i] = 9'($urandom & ((32'd1 << DB[inst]) - 32'd1));
      fork
        begin
          for (int i = 0; i < k; i++) do_write(inst, ws[i]);
        end
        begin
          wait_start(inst, 20);
          for (int i = 0; i < k; i++) check_frame(inst, ws[i], (i == k - 1));
        end
      join
    end
  endtask

  task automatic test_cs();
    cs_v[0] = 1'b0;
    we_v[0] = 1'b1;
    wd_v[0] = 9'h05A;
    repeat (8) begin
      @(negedge clk);
      checks++;
      if (lvl_v[0] !== 3'd0 || tx_v[0] !== 1'b1 || empty_v[0] !== 1'b1) begin
        errors++;
        $display("FAIL cs_gate: lvl=%0d tx=%b empty=%b, expected 0 1 1", lvl_v[0], tx_v[0], empty_v[0]);
      end
    end
    we_v[0] = 1'b0;
  endtask

  task automatic test_reset_midframe();
    do_write(0, 9'h03C);
    do_write(0, 9'h0C3);
    wait_start(0, 20);
    repeat (4 * C) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (tx_v[0] !== 1'b1 || empty_v[0] !== 1'b1 || busy_v[0] !== 1'b0 || lvl_v[0] !== 3'd0) begin
      errors++;
      $display("FAIL midframe_reset: tx=%b empty=%b busy=%b lvl=%0d, expected 1 1 0 0",
               tx_v[0], empty_v[0], busy_v[0], lvl_v[0]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (60) begin
      @(negedge clk);
      checks++;
      if (done_v[0] !== 1'b0 || tx_v[0] !== 1'b1) begin
        errors++;
        $display("FAIL after_reset: done=%b tx=%b, expected 0 1", done_v[0], tx_v[0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_8n1();
    test_parity();
    test_config();
    test_fifo();
    test_random();
    test_cs();
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end
endmodule
